ldtu_ofifo_secded: RTL

Parametrised output FIFO with SECDED protection on stored words. It is the next-generation output buffer between the compression/control unit and the 32-bit serialiser interface. Each word is encoded to an extended-Hamming codeword on write and decoded on read, so single-bit upsets are corrected and double-bit upsets are flagged. Width, depth, idle pattern and almost-full threshold are generic, and the block adds fill level, almost-full and sticky overflow status.

---
 rtl/ldtu_ofifo_pkg.sv | 44 ++++
 rtl/ldtu_secded_codec.sv | 85 ++++++++
 rtl/ldtu_ofifo_secded.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ldtu_ofifo_pkg.sv
// Shared constants and helpers for the SECDED-protected output FIFO.
// Codeword layout: Hamming positions 1..DATA_W+P map to bits [0..DATA_W+P-1],
// check bits at power-of-two positions, overall parity in the MSB.
package ldtu_ofifo_pkg;

  localparam int unsigned MaxDataW = 64;
  localparam int unsigned MaxCwW   = 72;

  localparam logic [31:0] IdlePatEa = 32'hEAAAAAAA;
  localparam logic [31:0] IdlePat5a = 32'h5A5A5A5A;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int unsigned calc_p(int unsigned data_w);
    int unsigned p;
    p = 0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (p == 0 && (32'd1 << i) >= data_w + i + 1) begin
        p = i;
      end
    end
    return p;
  endfunction

  function automatic int unsigned calc_cw_w(int unsigned data_w);
    return data_w + calc_p(data_w) + 1;
  endfunction

  localparam int unsigned CW_W = calc_cw_w(32);

  function automatic logic is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Bit b set when Hamming position b+1 is covered by check bit idx.
  function automatic logic [MaxCwW-1:0] parity_mask(int unsigned idx);
    logic [MaxCwW-1:0] m;
    m = '0;
    for (int unsigned pos = 1; pos <= MaxCwW; pos++) begin
      m[pos-1] = ((pos >> idx) & 32'd1) != 0;
    end
    return m;
  endfunction

endpackage

// File: rtl/ldtu_secded_codec.sv
// Combinational extended-Hamming encoder and decoder.
// Encode: data_i -> cw_o. Decode: cw_i -> data_o with sec_o / ded_o flags.
module ldtu_secded_codec
  import ldtu_ofifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned P     = calc_p(DATA_W),
  localparam int unsigned CwW   = DATA_W + P + 1
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CwW-1:0]    cw_o,
  input  logic [CwW-1:0]    cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sec_o,
  output logic              ded_o
);

  localparam int unsigned N = DATA_W + P;

  logic [N-1:0] enc_h;
  logic [N-1:0] dec_h;
  logic [P-1:0] dec_syn;
  logic         dec_par;

  // Scatter data into non-power-of-two positions, then fill in check bits.
  always_comb begin : p_enc
    int unsigned d;
    logic [MaxCwW-1:0] m;
    enc_h = '0;
    d     = 0;
    m     = '0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if (!is_pow2(pos)) begin
        enc_h[pos-1] = data_i[d];
        d++;
      end
    end
    // Each mask covers only its own power-of-two slot, so order does not matter.
    for (int unsigned i = 0; i < P; i++) begin
      m = parity_mask(i);
      enc_h[(32'd1 << i) - 1] = ^(enc_h & m[N-1:0]);
    end
    cw_o = {^enc_h, enc_h};
  end

  // Syndrome, overall parity, single-bit correction and data gather.
  always_comb begin : p_dec
    int unsigned d;
    logic [MaxCwW-1:0] m;
    dec_h   = cw_i[N-1:0];
    dec_syn = '0;
    dec_par = ^cw_i;
    sec_o   = 1'b0;
    ded_o   = 1'b0;
    data_o  = '0;
    d       = 0;
    m       = '0;
    for (int unsigned i = 0; i < P; i++) begin
      m          = parity_mask(i);
      dec_syn[i] = ^(dec_h & m[N-1:0]);
    end
    if (dec_syn != '0) begin
      if (dec_par) begin
        sec_o = 1'b1;
        for (int unsigned pos = 1; pos <= N; pos++) begin
          if (dec_syn == P'(pos)) begin
            dec_h[pos-1] = ~dec_h[pos-1];
          end
        end
      end else begin
        ded_o = 1'b1;
      end
    end else if (dec_par) begin
      // Only the overall parity bit flipped; payload is intact.
      sec_o = 1'b1;
    end
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if (!is_pow2(pos)) begin
        data_o[d] = dec_h[pos-1];
        d++;
      end
    end
  end

endmodule

// File: rtl/ldtu_ofifo_secded.sv
// SECDED-protected output FIFO between compression/control and serialiser.
// Optional build macro LDTU_OFIFO_ERR_INJECT_EN adds inj_en / inj_mask ports
// that XOR a mask into the stored codeword on accepted writes.
module ldtu_ofifo_secded
  import ldtu_ofifo_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PTR_W        = 4,
  parameter int unsigned AFULL_TH     = 12,
  parameter logic [63:0] IDLE_PATTERN = {32'h0, IdlePatEa},
  localparam int unsigned CwW         = calc_cw_w(DATA_W)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              write_signal,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_signal,
`ifdef LDTU_OFIFO_ERR_INJECT_EN
  input  logic              inj_en,
  input  logic [CwW-1:0]    inj_mask,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full_signal,
  output logic              almost_full,
  output logic              empty_signal,
  output logic [PTR_W:0]    fill_level,
  output logic              sec_error,
  output logic              ded_error,
  output logic              overflow,
  output logic              HammError
);

  localparam logic [DATA_W-1:0] IdleWord = IDLE_PATTERN[DATA_W-1:0];
  localparam logic [PTR_W:0]    DepthCnt = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]    AfullCnt = (PTR_W + 1)'(AFULL_TH);

  logic [CwW-1:0]    mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              sec_q, sec_d;
  logic              ded_q, ded_d;
  logic              hamm_q, hamm_d;

  logic              wr_en, rd_en;
  logic [CwW-1:0]    wr_cw, store_cw, rd_cw;
  logic [DATA_W-1:0] rd_data;
  logic              rd_sec, rd_ded;

  logic [DATA_W-1:0] unused_wr_data;
  logic              unused_wr_sec, unused_wr_ded;
  logic [CwW-1:0]    unused_rd_cw;

  ldtu_secded_codec #(
    .DATA_W(DATA_W)
  ) u_enc (
    .data_i(data_in),
    .cw_o  (wr_cw),
    .cw_i  (wr_cw),
    .data_o(unused_wr_data),
    .sec_o (unused_wr_sec),
    .ded_o (unused_wr_ded)
  );

  ldtu_secded_codec #(
    .DATA_W(DATA_W)
  ) u_dec (
    .data_i('0),
    .cw_o  (unused_rd_cw),
    .cw_i  (rd_cw),
    .data_o(rd_data),
    .sec_o (rd_sec),
    .ded_o (rd_ded)
  );

`ifdef LDTU_OFIFO_ERR_INJECT_EN
  assign store_cw = inj_en ? (wr_cw ^ inj_mask) : wr_cw;
`else
  assign store_cw = wr_cw;
`endif

  assign rd_cw = mem_q[rd_ptr_q];

  // FIFO control, status and output next-state.
  always_comb begin
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    wr_en    = write_signal && (!full_q || read_signal);
    rd_en    = read_signal && !empty_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, rd_en};
    full_d   = (count_d == DepthCnt);
    afull_d  = (count_d >= AfullCnt);
    empty_d  = (count_d == '0);
    ovf_d    = ovf_q | (write_signal && full_q && !read_signal);

    dout_d  = dout_q;
    valid_d = 1'b0;
    sec_d   = 1'b0;
    ded_d   = 1'b0;
    if (read_signal) begin
      if (rd_en) begin
        dout_d  = rd_data;
        valid_d = 1'b1;
        sec_d   = rd_sec;
        ded_d   = rd_ded;
      end else begin
        dout_d = IdleWord;
      end
    end
    hamm_d = sec_d | ded_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      dout_q   <= IdleWord;
      valid_q  <= 1'b0;
      sec_q    <= 1'b0;
      ded_q    <= 1'b0;
      hamm_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      sec_q    <= sec_d;
      ded_q    <= ded_d;
      hamm_q   <= hamm_d;
    end
  end

  // Codeword storage; contents are not reset.
  always_ff @(posedge CLK) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= store_cw;
    end
  end

  assign data_out     = dout_q;
  assign data_valid   = valid_q;
  assign full_signal  = full_q;
  assign almost_full  = afull_q;
  assign empty_signal = empty_q;
  assign fill_level   = count_q;
  assign sec_error    = sec_q;
  assign ded_error    = ded_q;
  assign overflow     = ovf_q;
  assign HammError    = hamm_q;

endmodule
